// File: rtl/jogo_sequencia_param_if.sv
// Sequence ROM port: the game addresses the ROM and reads its word back combinationally.
interface jogo_sequencia_param_if #(
    parameter int unsigned N_CHAVES = 4,
    parameter int unsigned AW       = 4
);
    logic [AW-1:0]       seq_addr;
    logic [N_CHAVES-1:0] seq_data;

    modport master (output seq_addr, input  seq_data);
    modport slave  (input  seq_addr, output seq_data);
endinterface

// File: rtl/jogo_sequencia_param.sv
// Growing-sequence memory game: round k requires repeating ROM entries 0..k,
// with a run-time round limit, multi-key rejection and a per-play timeout.
module jogo_sequencia_param #(
    parameter int unsigned N_CHAVES = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TIMEOUT  = 3000,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [AW:0]         limite,
    input  logic [N_CHAVES-1:0] chaves,
    jogo_sequencia_param_if.master rom,
    output logic [N_CHAVES-1:0] leds,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [3:0]          db_estado,
    output logic [AW-1:0]       db_rodada,
    output logic [AW-1:0]       db_jogada
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARA     = 4'h4,
        PROX_JOGADA = 4'h5,
        PROX_RODADA = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hF
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       rodada_q, rodada_d;
    logic [AW-1:0]       jogada_q, jogada_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [LW-1:0]       lim_q, lim_d;
    logic [N_CHAVES-1:0] leds_q, leds_d;
    logic [N_CHAVES-1:0] jreg_q, jreg_d;
    logic [N_CHAVES-1:0] chaves_prev_q;
    logic                pronto_q, pronto_d;
    logic                acertou_q, acertou_d;
    logic                errou_q, errou_d;
    logic                timeout_q, timeout_d;

    logic                tem_jogada_c;
    logic [LW-1:0]       lim_clamp_c;

    // A play is the rising edge of "any key down"; held keys count once.
    assign tem_jogada_c = (chaves != '0) && (chaves_prev_q == '0);
    assign lim_clamp_c  = ((limite == '0) || (limite > LW'(DEPTH))) ? LW'(DEPTH) : limite;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= INICIAL;
            rodada_q      <= '0;
            jogada_q      <= '0;
            tmr_q         <= '0;
            lim_q         <= '0;
            leds_q        <= '0;
            jreg_q        <= '0;
            chaves_prev_q <= '0;
            pronto_q      <= 1'b0;
            acertou_q     <= 1'b0;
            errou_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rodada_q      <= rodada_d;
            jogada_q      <= jogada_d;
            tmr_q         <= tmr_d;
            lim_q         <= lim_d;
            leds_q        <= leds_d;
            jreg_q        <= jreg_d;
            chaves_prev_q <= chaves;
            pronto_q      <= pronto_d;
            acertou_q     <= acertou_d;
            errou_q       <= errou_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rodada_d = rodada_q;
        jogada_d = jogada_q;
        tmr_d    = tmr_q;
        lim_d    = lim_q;
        leds_d   = leds_q;
        jreg_d   = jreg_q;

        case (state_q)
            INICIAL: begin
                if (iniciar) state_d = PREPARA;
            end
            PREPARA: begin
                lim_d    = lim_clamp_c;
                rodada_d = '0;
                jogada_d = '0;
                leds_d   = '0;
                tmr_d    = '0;
                state_d  = ESPERA;
            end
            ESPERA: begin
                tmr_d = tmr_q + TW'(1);
                // A play in the last allowed cycle still beats the timeout.
                if (tem_jogada_c)                    state_d = REGISTRA;
                else if (tmr_q == TW'(TIMEOUT - 1)) state_d = FIM_TIMEOUT;
            end
            REGISTRA: begin
                jreg_d  = chaves;
                leds_d  = chaves;
                state_d = COMPARA;
            end
            COMPARA: begin
                if (!$onehot(jreg_q) || (jreg_q != rom.seq_data)) state_d = FIM_ERRO;
                else if (jogada_q < rodada_q)                     state_d = PROX_JOGADA;
                else if ({1'b0, rodada_q} == lim_q - LW'(1))      state_d = FIM_ACERTO;
                else                                              state_d = PROX_RODADA;
            end
            PROX_JOGADA: begin
                jogada_d = jogada_q + AW'(1);
                tmr_d    = '0;
                state_d  = ESPERA;
            end
            PROX_RODADA: begin
                rodada_d = rodada_q + AW'(1);
                jogada_d = '0;
                tmr_d    = '0;
                state_d  = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) state_d = PREPARA;
            end
            default: state_d = INICIAL;
        endcase

        // Flags are registered copies of the outcome encoded by the next state.
        pronto_d  = (state_d == FIM_ACERTO) || (state_d == FIM_ERRO) || (state_d == FIM_TIMEOUT);
        acertou_d = (state_d == FIM_ACERTO);
        errou_d   = (state_d == FIM_ERRO) || (state_d == FIM_TIMEOUT);
        timeout_d = (state_d == FIM_TIMEOUT);
    end

    assign rom.seq_addr = jogada_q;
    assign leds         = leds_q;
    assign pronto       = pronto_q;
    assign acertou      = acertou_q;
    assign errou        = errou_q;
    assign timeout      = timeout_q;
    assign db_estado    = state_q;
    assign db_rodada    = rodada_q;
    assign db_jogada    = jogada_q;
endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Scoreboard bench: each game's outcome is predicted from the game rules and
// checked by a monitor when the DUT raises pronto.
module tb_jogo_sequencia_param;
    localparam int unsigned N       = 4;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 3000;
    localparam int unsigned AW      = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]    estado;
        logic          acertou;
        logic          errou;
        logic          tmo;
        logic [N-1:0]  leds;
        logic [AW-1:0] rodada;
        logic [AW-1:0] jogada;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          iniciar = 1'b0;
    logic [AW:0]   limite = '0;
    logic [N-1:0]  chaves = '0;
    logic [N-1:0]  leds;
    logic          pronto, acertou, errou, timeout;
    logic [3:0]    db_estado;
    logic [AW-1:0] db_rodada, db_jogada;

    logic [N-1:0]  rom_mem [DEPTH];
    logic [N-1:0]  pl [$];
    exp_t          exp_q [$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    logic          pronto_prev = 1'b0;
    logic [3:0]    prev_estado = 4'h0;
    int            esp_cnt = 0;

    jogo_sequencia_param_if #(.N_CHAVES(N), .AW(AW)) rom ();
    assign rom.seq_data = rom_mem[rom.seq_addr];

    jogo_sequencia_param #(.N_CHAVES(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .limite(limite),
        .chaves(chaves), .rom(rom.master), .leds(leds), .pronto(pronto),
        .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado), .db_rodada(db_rodada), .db_jogada(db_jogada)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected outcome from the rules: round r needs entries 0..r in order.
    function automatic exp_t model(input int lim_in);
        exp_t e;
        int   lim_eff = (lim_in == 0 || lim_in > int'(DEPTH)) ? int'(DEPTH) : lim_in;
        int   k = 0;
        logic [N-1:0] last = '0;
        for (int r = 0; r < lim_eff; r++) begin
            for (int j = 0; j <= r; j++) begin
                if (k >= pl.size()) begin
                    e = '{4'hF, 1'b0, 1'b1, 1'b1, last, AW'(r), AW'(j)};
                    return e;
                end
                last = pl[k];
                k++;
                if ($countones(last) != 1 || last != rom_mem[j]) begin
                    e = '{4'hE, 1'b0, 1'b1, 1'b0, last, AW'(r), AW'(j)};
                    return e;
                end
            end
        end
        e = '{4'hA, 1'b1, 1'b0, 1'b0, last, AW'(lim_eff - 1), AW'(lim_eff - 1)};
        return e;
    endfunction

    // Monitor: pops the prediction when a game ends; also times every timeout.
    always @(negedge clock) begin
        pronto_prev <= pronto;
        prev_estado <= db_estado;
        if (db_estado == 4'h2) esp_cnt <= (prev_estado == 4'h2) ? esp_cnt + 1 : 1;
        if (reset && db_estado == 4'hF && prev_estado == 4'h2)
            check("timeout_cycles", esp_cnt, TIMEOUT);
        if (reset && pronto && !pronto_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_end", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("end_estado",  db_estado, mon_e.estado);
                check("end_flags",   {acertou, errou, timeout}, {mon_e.acertou, mon_e.errou, mon_e.tmo});
                check("end_leds",    leds, mon_e.leds);
                check("end_rodada",  db_rodada, mon_e.rodada);
                check("end_jogada",  db_jogada, mon_e.jogada);
            end
        end
    end

    task automatic start(input int lim);
        limite  = (AW + 1)'(lim);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("prepara_estado", db_estado, 4'h1);
        check("prepara_flags", {pronto, acertou, errou, timeout}, 4'b0000);
        repeat (2) @(negedge clock);
    endtask

    task automatic press(input logic [N-1:0] k, input int hold, input int rel);
        chaves = k;
        repeat (hold) @(negedge clock);
        chaves = '0;
        repeat (rel) @(negedge clock);
    endtask

    task automatic run_game(input int lim, input int long_idx, input logic [31:0] long_exp);
        int waited = 0;
        exp_q.push_back(model(lim));
        start(lim);
        for (int i = 0; i < pl.size(); i++) begin
            press(pl[i], (i == long_idx) ? 40 : int'($urandom_range(2, 6)), int'($urandom_range(4, 8)));
            if (i == long_idx) check("held_one_play", db_jogada, long_exp);
        end
        while (!pronto && waited < int'(TIMEOUT) + 100) begin
            @(negedge clock);
            waited++;
        end
        if (!pronto) check("game_end_bound", 0, 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic gen_game(input int lim_in, input int kind);
        int lim_eff = (lim_in == 0 || lim_in > int'(DEPTH)) ? int'(DEPTH) : lim_in;
        int total   = lim_eff * (lim_eff + 1) / 2;
        int s       = (kind == 0) ? total : int'($urandom_range(0, total - 1));
        int k       = 0;
        int sj      = 0;
        logic [N-1:0] bad;
        pl.delete();
        for (int r = 0; r < lim_eff; r++)
            for (int j = 0; j <= r; j++) begin
                if (k < s) pl.push_back(rom_mem[j]);
                if (k == s) sj = j;
                k++;
            end
        if (kind == 1) begin
            do bad = N'($urandom_range(1, (1 << N) - 1)); while (bad == rom_mem[sj]);
            pl.push_back(bad);
        end
        run_game(lim_in, -1, 0);
    endtask

    task automatic rand_rom();
        for (int i = 0; i < int'(DEPTH); i++) rom_mem[i] = N'(1) << $urandom_range(0, N - 1);
    endtask

    initial begin
        int tmo_left = 2;
        int waited;
        int k0;
        rand_rom();
        rom_mem[0] = 4'b0001;
        rom_mem[1] = 4'b0010;
        rom_mem[2] = 4'b0100;

        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_estado", db_estado, 4'h0);
        check("rst_flags", {pronto, acertou, errou, timeout}, 4'b0000);
        check("rst_leds", leds, 4'b0000);
        check("rst_addr", rom.seq_addr, 0);

        pl.delete();
        pl.push_back(4'b0001);
        pl.push_back(4'b0001); pl.push_back(4'b0010);
        pl.push_back(4'b0001); pl.push_back(4'b0010); pl.push_back(4'b0100);
        run_game(3, -1, 0);

        pl.delete();
        pl.push_back(4'b0001); pl.push_back(4'b0001); pl.push_back(4'b0100);
        run_game(3, -1, 0);
        repeat (50) @(negedge clock);
        check("erro_holds", db_estado, 4'hE);

        pl.delete();
        pl.push_back(4'b0001); pl.push_back(4'b0001); pl.push_back(4'b0010);
        run_game(16, -1, 0);
        press(4'b0001, 5, 3);
        check("tmo_ignores_keys", db_estado, 4'hF);
        check("tmo_leds", leds, 4'b0010);

        pl.delete();
        pl.push_back(4'b0001); pl.push_back(4'b0001); pl.push_back(4'b0011);
        run_game(3, 1, 1);

        gen_game(0, 0);

        start(5);
        chaves = 4'b0001;
        waited = 0;
        while (db_estado != 4'h4 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("reach_compara", db_estado, 4'h4);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_estado", db_estado, 4'h0);
        check("midrst_leds_jogada", {leds, db_jogada}, 0);
        chaves = '0;
        reset  = 1'b1;
        repeat (2) @(negedge clock);

        for (int g = 0; g < 10; g++) begin
            rand_rom();
            k0 = int'($urandom_range(0, 5));
            if (k0 == 0 && tmo_left > 0) begin
                tmo_left--;
                gen_game(int'($urandom_range(0, DEPTH + 3)), 2);
            end else begin
                gen_game(int'($urandom_range(0, DEPTH + 3)), (k0 <= 2) ? 1 : 0);
            end
        end

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jogo_sequencia_param.md
Name: jogo_sequencia_param

Overview:
- Parametrised successor of the exp5 memory-game datapath/control. It plays a growing-sequence game: round k requires the player to repeat sequence entries 0..k.
- Generalised over key count (N_CHAVES), sequence depth (DEPTH) and per-play timeout (TIMEOUT).
- Adds a run-time round limit, invalid-play (multi-key) detection and a distinct timeout outcome.
- Sits between the board switches/LEDs and an external sequence ROM; the sequence ROM is addressed by this block.

Parameters:
- N_CHAVES, 4, number of keys/LEDs; a valid play is one-hot on N_CHAVES bits.
- DEPTH, 16, maximum sequence length = maximum rounds; power of two, >= 2.
- TIMEOUT, 3000, clock cycles allowed per play while waiting (3 s at 1 kHz).
- AW, $clog2(DEPTH), address width, derived.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- iniciar  in  1  start/restart request, level-sampled each cycle.
- limite  in  AW+1  rounds to win, sampled when a start is accepted; 0 or >DEPTH is clamped to DEPTH.
- chaves  in  N_CHAVES  player keys, already synchronised.
- seq_addr  out  AW  ROM address = current play index.
- seq_data  in  N_CHAVES  ROM word, combinational read, valid in the same cycle as seq_addr.
- leds  out  N_CHAVES  last registered play.
- pronto  out  1  game finished (any outcome).
- acertou  out  1  game won.
- errou  out  1  wrong play, invalid play or timeout.
- timeout  out  1  finished by timeout.
- db_estado  out  4  FSM state code.
- db_rodada  out  AW  current round index.
- db_jogada  out  AW  current play index.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to INICIAL.
  - Rodada, jogada and timeout counters, lim_reg, leds and chaves_prev are cleared.
  - All flags are 0.
  - Reset overrides every other input, including mid-game.
- State codes:
  - INICIAL=0, PREPARA=1, ESPERA=2, REGISTRA=3, COMPARA=4
  - PROX_JOGADA=5, PROX_RODADA=6
  - FIM_ACERTO=A, FIM_ERRO=E, FIM_TIMEOUT=F
- Play detection:
  - chaves_prev is a register updated every cycle.
  - tem_jogada = (chaves!=0) && (chaves_prev==0).
  - Keys held down produce a single play.
- INICIAL:
  - iniciar=1 -> PREPARA.
- PREPARA (1 cycle):
  - Load lim_reg from the clamped limite.
  - Clear rodada, jogada, leds and the timeout counter.
  - Next state ESPERA.
- ESPERA:
  - The timeout counter increments each cycle; it is cleared on every entry to ESPERA.
  - tem_jogada -> REGISTRA.
  - Otherwise, counter==TIMEOUT-1 -> FIM_TIMEOUT.
  - If tem_jogada occurs in the same cycle the counter reaches TIMEOUT-1, the play wins.
  - iniciar is ignored in this state.
- REGISTRA:
  - jogada_reg <= chaves and leds <= chaves.
  - Next state COMPARA.
- COMPARA, with seq_addr=jogada:
  - jogada_reg not one-hot -> FIM_ERRO.
  - jogada_reg != seq_data -> FIM_ERRO.
  - Match and jogada<rodada -> PROX_JOGADA.
  - Match and jogada==rodada and rodada==lim_reg-1 -> FIM_ACERTO.
  - Match and jogada==rodada otherwise -> PROX_RODADA.
- PROX_JOGADA: jogada+1, then ESPERA.
- PROX_RODADA: rodada+1, jogada=0, then ESPERA.
- Counter limits: counters never exceed DEPTH-1, so there is no wrap.
- Latency: a valid play sampled in ESPERA at edge t enters REGISTRA at t+1, COMPARA at t+2, and the next state at t+3.
- Final states (outputs are Moore, registered from state):
  - pronto=1 in all FIM_* states.
  - acertou=1 only in FIM_ACERTO.
  - errou=1 in FIM_ERRO and FIM_TIMEOUT.
  - timeout=1 only in FIM_TIMEOUT.
  - Flags hold until iniciar=1 -> PREPARA, which clears them on the next edge, or until reset.
- seq_addr=jogada in all states.

Test Plan:
- Reset then idle: reset=0 for 10 cycles, release -> db_estado=0, all flags 0, leds=0000, seq_addr=0.
- Full win, limite=3, ROM 0001,0010,0100: one-hot plays with 5-cycle press and 5-cycle release (round1: 0001; round2: 0001,0010; round3: 0001,0010,0100) -> FIM_ACERTO, pronto=1, acertou=1, errou=0, db_rodada=2.
- Wrong play in round 2, second play 0100 instead of 0010 -> db_estado=E, errou=1, timeout=0, leds=0100; the FSM stays in E for 50 more cycles.
- Timeout in round 3, limite=16, TIMEOUT=3000: after 0001,0010, hold chaves=0 for 3100 cycles -> db_estado=F exactly TIMEOUT cycles after entering ESPERA, with errou=1 and timeout=1; later key presses are ignored.
- Invalid or held keys: chaves=0011 -> FIM_ERRO. Holding 0001 for 40 cycles in round 2 counts as one play (db_jogada becomes 1, not 2).
- Restart and mid-game reset:
  - In FIM_TIMEOUT, iniciar=1 -> PREPARA, flags 0, new limite sampled.
  - With limite=0 the game runs to 16 rounds.
  - reset=0 asserted while in COMPARA -> INICIAL on the next edge.
